byte_striping: RTL and testbench
================================

Name: byte_striping

Overview:
Transmit-side counterpart of the PHY byte unstriper. It takes one byte stream at the clk_2f rate and distributes consecutive bytes alternately onto two byte lanes, lane_0 first. Each lane carries its own valid flag. Invalid slots are filled with a configurable idle byte. Per-lane byte counters and a slot-phase strobe are provided for the downstream serializer and for debug.

Parameters:
DATA_WIDTH, 8, width of data_in and each lane
IDLE_BYTE, 8'h00, value driven on a lane for a slot whose valid is 0
PACK, 0, 0 = slot-locked lane selection (toggles every cycle); 1 = packed (toggles only on valid bytes)
CNT_WIDTH, 16, width of the per-lane valid-byte counters

Ports:
clk_2f  input  1  single clock, byte rate; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  DATA_WIDTH  incoming byte
valid_in  input  1  data_in qualifier
lane_0  output  DATA_WIDTH  even-slot lane byte
lane_1  output  DATA_WIDTH  odd-slot lane byte
valid_0  output  1  lane_0 qualifier
valid_1  output  1  lane_1 qualifier
sel  output  1  lane that the next accepted slot will write (0/1)
lane_cnt_0  output  CNT_WIDTH  count of valid bytes sent on lane 0, saturating
lane_cnt_1  output  CNT_WIDTH  count of valid bytes sent on lane 1, saturating

Behaviour:
- Reset state: lane_0 = lane_1 = 0, valid_0 = valid_1 = 0, sel = 0, lane_cnt_0 = lane_cnt_1 = 0. The state is forced asynchronously while reset = 1.
- Latency: 1 clk_2f. A byte sampled at edge N appears on its lane after edge N. Both lane outputs are registered.
- Write rule at each edge, with s = current sel:
  - If valid_in = 1: lane_s <= data_in and valid_s <= 1.
  - If valid_in = 0: lane_s <= IDLE_BYTE and valid_s <= 0.
  - The other lane holds its value and its valid flag. Each lane therefore changes at most every other slot in slot-locked mode.
- sel update:
  - PACK = 0: sel <= ~sel every edge, independent of valid_in. Lane 0 is always the even slot after reset.
  - PACK = 1: sel <= ~sel only when valid_in = 1. An invalid cycle rewrites lane_s as idle/invalid, and the next valid byte still goes to lane s.
- Counters: lane_cnt_s increments on each valid write to lane s. A counter saturates at all-ones and does not wrap.
- First cycle after reset deasserts: slot 0 goes to lane 0 regardless of valid_in.
- Reset mid-stream: all outputs and sel clear at once. A byte present on the deassertion edge is processed normally as slot 0.
- valid_in held constantly at 1: the lanes alternate, giving a strict order data[0]->lane_0, data[1]->lane_1, data[2]->lane_0, and so on.
- No backpressure. The block accepts a byte every cycle.
- Round trip: byte_unstriping fed with lane_0/lane_1/valid_0/valid_1 from this block reproduces the original valid byte sequence in order. This holds for PACK = 0 with any valid pattern, and for PACK = 1.

Decomposition:
- Shared phy package holds:
  - DATA_WIDTH default
  - IDLE_BYTE default (shared with the unstriper's idle check)
  - lane index constants LANE0 = 0, LANE1 = 1
- One natural sub-module, lane_reg: a per-lane data/valid register plus saturating counter, instantiated twice with write enable (sel == index).
- Top level holds the sel logic and the PACK selection.

Test Plan:
- Reset behaviour: hold reset = 1 with valid_in = 1 and data_in = 8'hFF, then deassert. Required: all outputs stay 0 during reset; after the first edge, lane_0 = FF, valid_0 = 1, sel = 1.
- Back-to-back stream, PACK = 0: FF, EE, DD, CC with valid_in = 1. Required: lane_0 = FF then DD, lane_1 = EE then CC, each presented 1 cycle after input; lane_cnt_0 = lane_cnt_1 = 2.
- Gap, PACK = 0: 03 valid, X invalid, X invalid, 04 valid. Required:
  - lane_0 = 03 with valid_0 = 1.
  - lane_1 = IDLE with valid_1 = 0.
  - lane_0 = IDLE with valid_0 = 0.
  - lane_1 = 04 with valid_1 = 1.
- Gap, PACK = 1, same input as the gap scenario. Required:
  - 03 goes to lane_0.
  - The invalid cycles write IDLE with valid_1 = 0 on lane_1, and sel stays 1.
  - 04 goes to lane_1 with valid_1 = 1.
- Reset mid-stream: assert reset asynchronously between edges after AA has been sent on lane_0. Required: outputs clear immediately without a clock edge; after release, the next byte 99 goes to lane_0.
- Counter saturation (CNT_WIDTH = 4): send 40 valid bytes. Required: lane_cnt_0 = lane_cnt_1 = 4'hF with no wrap; round trip through byte_unstriping matches the input sequence.

Source files
------------

// File: rtl/byte_striping_pkg.sv
// Shared PHY byte-lane definitions used by the striper and the unstriper's idle check.
package byte_striping_pkg;

  localparam int              PHY_DATA_WIDTH = 8;
  localparam logic [7:0]      PHY_IDLE_BYTE  = 8'h00;
  localparam int              PHY_CNT_WIDTH  = 16;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/byte_striping_lane_reg.sv
// One output lane: registered byte/valid, idle fill on invalid writes, saturating byte counter.
// Updates only on edges where i_wr_en is set; otherwise everything holds.
module byte_striping_lane_reg
  import byte_striping_pkg::*;
#(
  parameter int                    DATA_WIDTH = PHY_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = DATA_WIDTH'(PHY_IDLE_BYTE),
  parameter int                    CNT_WIDTH  = PHY_CNT_WIDTH
) (
  input  logic                  i_clk_2f,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_vld,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_vld,
  output logic [CNT_WIDTH-1:0]  o_cnt
);

  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_vld;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_cnt_max;

  assign w_cnt_max = (r_cnt == {CNT_WIDTH{1'b1}});

  always_ff @(posedge i_clk_2f or posedge i_rst) begin
    if (i_rst) begin
      r_dat <= '0;
      r_vld <= 1'b0;
      r_cnt <= '0;
    end else if (i_wr_en) begin
      r_vld <= i_vld;
      r_dat <= i_vld ? i_dat : IDLE_BYTE;
      // Counter sticks at all-ones so debug reads never see a wrapped value.
      if (i_vld && !w_cnt_max)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_dat = r_dat;
  assign o_vld = r_vld;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/byte_striping.sv
// Splits one byte stream onto two lanes (lane 0 first), 1 cycle latency, no backpressure.
// PACK=0 alternates lanes every slot; PACK=1 alternates only on valid bytes.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int                    DATA_WIDTH = PHY_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = DATA_WIDTH'(PHY_IDLE_BYTE),
  parameter int                    PACK       = 0,
  parameter int                    CNT_WIDTH  = PHY_CNT_WIDTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic                  sel,
  output logic [CNT_WIDTH-1:0]  lane_cnt_0,
  output logic [CNT_WIDTH-1:0]  lane_cnt_1
);

  logic r_sel;
  logic w_sel_nxt;
  logic w_wr_en_0;
  logic w_wr_en_1;

  always_comb begin
    w_sel_nxt = r_sel;
    if ((PACK == 0) || valid_in)
      w_sel_nxt = ~r_sel;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset)
      r_sel <= LANE0;
    else
      r_sel <= w_sel_nxt;
  end

  assign w_wr_en_0 = (r_sel == LANE0);
  assign w_wr_en_1 = (r_sel == LANE1);

  byte_striping_lane_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDLE_BYTE  (IDLE_BYTE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_lane_0 (
    .i_clk_2f (clk_2f),
    .i_rst    (reset),
    .i_wr_en  (w_wr_en_0),
    .i_dat    (data_in),
    .i_vld    (valid_in),
    .o_dat    (lane_0),
    .o_vld    (valid_0),
    .o_cnt    (lane_cnt_0)
  );

  byte_striping_lane_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDLE_BYTE  (IDLE_BYTE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_lane_1 (
    .i_clk_2f (clk_2f),
    .i_rst    (reset),
    .i_wr_en  (w_wr_en_1),
    .i_dat    (data_in),
    .i_vld    (valid_in),
    .o_dat    (lane_1),
    .o_vld    (valid_1),
    .o_cnt    (lane_cnt_1)
  );

  assign sel = r_sel;

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboarded bench: slot-locked, packed and 4-bit-counter instances share one input stream.
module tb_byte_striping;

  localparam logic [7:0] IDLE = 8'hA5;

  logic       clk_2f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;

  logic [7:0]  a_lane_0, a_lane_1, b_lane_0, b_lane_1, c_lane_0, c_lane_1;
  logic        a_valid_0, a_valid_1, b_valid_0, b_valid_1, c_valid_0, c_valid_1;
  logic        a_sel, b_sel, c_sel;
  logic [15:0] a_cnt_0, a_cnt_1, b_cnt_0, b_cnt_1;
  logic [3:0]  c_cnt_0, c_cnt_1;

  byte_striping #(.DATA_WIDTH(8), .IDLE_BYTE(IDLE), .PACK(0), .CNT_WIDTH(16)) dut_a (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(a_lane_0), .lane_1(a_lane_1), .valid_0(a_valid_0), .valid_1(a_valid_1),
    .sel(a_sel), .lane_cnt_0(a_cnt_0), .lane_cnt_1(a_cnt_1));

  byte_striping #(.DATA_WIDTH(8), .IDLE_BYTE(IDLE), .PACK(1), .CNT_WIDTH(16)) dut_b (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(b_lane_0), .lane_1(b_lane_1), .valid_0(b_valid_0), .valid_1(b_valid_1),
    .sel(b_sel), .lane_cnt_0(b_cnt_0), .lane_cnt_1(b_cnt_1));

  byte_striping #(.DATA_WIDTH(8), .IDLE_BYTE(IDLE), .PACK(0), .CNT_WIDTH(4)) dut_c (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(c_lane_0), .lane_1(c_lane_1), .valid_0(c_valid_0), .valid_1(c_valid_1),
    .sel(c_sel), .lane_cnt_0(c_cnt_0), .lane_cnt_1(c_cnt_1));

  // Expected result of one clocked slot: byte/valid, lane hit and resulting sel for
  // the slot-locked (s) and packed (p) instances.
  typedef struct {
    logic [7:0] dat;
    logic       vld;
    logic       ln_s;
    logic       ln_p;
    logic       sel_s;
    logic       sel_p;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one slot at a negedge, queue its expectation, move to the next negedge.
  task automatic slot(input logic [7:0] d, input logic v, input logic ln_s, input logic ln_p,
                      input logic sel_s, input logic sel_p);
    exp_t e;
    data_in  = d;
    valid_in = v;
    e.dat = v ? d : IDLE;
    e.vld = v;
    e.ln_s = ln_s;
    e.ln_p = ln_p;
    e.sel_s = sel_s;
    e.sel_p = sel_p;
    q.push_back(e);
    @(negedge clk_2f);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_2f);
    @(negedge clk_2f);
    reset = 1'b0;
  endtask

  // Monitor: every clocked slot leaves exactly one expectation to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2f);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("a_lane_dat", e.ln_s ? a_lane_1 : a_lane_0, e.dat);
        check("a_lane_vld", e.ln_s ? a_valid_1 : a_valid_0, e.vld);
        check("a_sel", a_sel, e.sel_s);
        check("c_lane_dat", e.ln_s ? c_lane_1 : c_lane_0, e.dat);
        check("c_lane_vld", e.ln_s ? c_valid_1 : c_valid_0, e.vld);
        check("c_sel", c_sel, e.sel_s);
        check("b_lane_dat", e.ln_p ? b_lane_1 : b_lane_0, e.dat);
        check("b_lane_vld", e.ln_p ? b_valid_1 : b_valid_0, e.vld);
        check("b_sel", b_sel, e.sel_p);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hFF;

    // Reset held with a valid byte present: nothing may leak out.
    repeat (3) @(negedge clk_2f);
    check("rst_lane_0", a_lane_0, 8'h00);
    check("rst_lane_1", a_lane_1, 8'h00);
    check("rst_valid_0", a_valid_0, 1'b0);
    check("rst_valid_1", a_valid_1, 1'b0);
    check("rst_sel", a_sel, 1'b0);
    check("rst_cnt_0", a_cnt_0, 16'h0);
    check("rst_cnt_1", a_cnt_1, 16'h0);
    check("rst_b_lane_0", b_lane_0, 8'h00);
    reset = 1'b0;
    slot(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Back-to-back stream.
    do_reset();
    slot(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    slot(8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    slot(8'hDD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    slot(8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b_a_cnt_0", a_cnt_0, 16'd2);
    check("b2b_a_cnt_1", a_cnt_1, 16'd2);
    check("b2b_b_cnt_0", b_cnt_0, 16'd2);
    check("b2b_b_cnt_1", b_cnt_1, 16'd2);

    // Gap: slot-locked keeps toggling, packed parks on lane 1.
    do_reset();
    slot(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    slot(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    slot(8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    slot(8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_a_lane_0", a_lane_0, IDLE);
    check("gap_a_valid_0", a_valid_0, 1'b0);
    check("gap_b_lane_0_hold", b_lane_0, 8'h03);
    check("gap_b_valid_0_hold", b_valid_0, 1'b1);
    check("gap_a_cnt_1", a_cnt_1, 16'd1);
    check("gap_b_cnt_1", b_cnt_1, 16'd1);

    // Asynchronous reset mid-stream, clear visible with no clock edge.
    do_reset();
    slot(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_lane_0", a_lane_0, 8'h00);
    check("mid_valid_0", a_valid_0, 1'b0);
    check("mid_sel", a_sel, 1'b0);
    check("mid_cnt_0", a_cnt_0, 16'h0);
    check("mid_b_lane_0", b_lane_0, 8'h00);
    @(negedge clk_2f);
    reset = 1'b0;
    slot(8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Long valid run: strict alternation and counter saturation.
    do_reset();
    for (int i = 0; i < 40; i++)
      slot(8'(i * 3 + 16), 1'b1, i[0], i[0], ~i[0], ~i[0]);
    check("sat_c_cnt_0", c_cnt_0, 4'hF);
    check("sat_c_cnt_1", c_cnt_1, 4'hF);
    check("sat_a_cnt_0", a_cnt_0, 16'd20);
    check("sat_a_cnt_1", a_cnt_1, 16'd20);
    check("sat_b_cnt_0", b_cnt_0, 16'd20);

    do_reset();
    repeat (3) @(negedge clk_2f);
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
